// File: rtl/seq_run_ctrl_pkg.sv
// Shared state encoding and step-index helper for the light-pattern run controller.
package seq_run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  function automatic logic [3:0] idx_next(input logic [3:0] idx, input logic [3:0] last);
    return (idx == last) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/seq_run_ctrl_tick_div.sv
// Step-rate divider: counts enabled clocks, tick is high on the enabled clock where the count is TICK_DIV-1.
module tick_div #(
  parameter int TICK_DIV = 500,
  parameter int CNT_W    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller for the 3-bit pattern stepper: button pulses -> step_en / seq_clr / boundary-aligned mode.
// Optional auto-stop after RUN_CYCLES pattern cycles when SEQ_RUN_LIMIT_EN is defined.
module seq_run_ctrl
  import seq_run_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 500,
  parameter int CNT_W      = 9,
  parameter int CYCLE_LEN  = 8,
  parameter int RUN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               CR_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               step,
  input  logic               mode_req,
  output logic               step_en,
  output logic               seq_clr,
  output logic               mode_out,
  output logic               mode_pend,
  output logic [3:0]         step_idx,
  output logic [STATE_W-1:0] state_o,
  output logic               done
);

  localparam logic [3:0] IDX_LAST = 4'(CYCLE_LEN - 1);

  state_t state;
  logic   tick, tmr_en, tmr_clr;
  logic   adv, wrap, mode_nxt, limit_hit;

  // Timer is frozen on the edge a pause/stop is taken so resume loses no counts.
  assign tmr_en  = (state == S_RUN) && !stop && !pause;
  assign tmr_clr = (state == S_IDLE) || stop;

  tick_div #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick_div (
    .clk   (clk),
    .rst_n (CR_n),
    .en    (tmr_en),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  always_comb begin
    adv      = tick || ((state == S_PAUSE) && step && !stop && !start && !pause);
    wrap     = adv && (step_idx == IDX_LAST);
    mode_nxt = ((state == S_IDLE) || wrap) ? mode_req : mode_out;
  end

`ifdef SEQ_RUN_LIMIT_EN
  localparam int CYC_W = $clog2(RUN_CYCLES + 1);
  logic [CYC_W-1:0] cyc_cnt;

  assign limit_hit = wrap && (cyc_cnt == CYC_W'(RUN_CYCLES - 1));

  always_ff @(posedge clk or negedge CR_n) begin
    if (!CR_n) begin
      cyc_cnt <= '0;
    end else if (stop || (state == S_IDLE) || limit_hit) begin
      cyc_cnt <= '0;
    end else if (wrap) begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign state_o = state;

  always_ff @(posedge clk or negedge CR_n) begin
    if (!CR_n) begin
      state     <= S_IDLE;
      step_en   <= 1'b0;
      seq_clr   <= 1'b0;
      mode_out  <= 1'b0;
      mode_pend <= 1'b0;
      step_idx  <= 4'd0;
      done      <= 1'b0;
    end else begin
      step_en   <= 1'b0;
      seq_clr   <= 1'b0;
      done      <= limit_hit;
      mode_out  <= mode_nxt;
      mode_pend <= mode_req ^ mode_nxt;
      if (adv) step_idx <= idx_next(step_idx, IDX_LAST);
      case (state)
        S_IDLE: begin
          if (stop) begin
            seq_clr <= 1'b1;
          end else if (start) begin
            state    <= S_RUN;
            seq_clr  <= 1'b1;
            step_idx <= 4'd0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state    <= S_IDLE;
            seq_clr  <= 1'b1;
            step_idx <= 4'd0;
          end else if (pause) begin
            state <= S_PAUSE;
          end else if (tick) begin
            step_en <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state    <= S_IDLE;
            seq_clr  <= 1'b1;
            step_idx <= 4'd0;
          end else if (start || pause) begin
            state <= S_RUN;
          end else if (step) begin
            step_en <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Auto-stop keeps the last pattern on display: no seq_clr here.
      if (limit_hit) state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Directed bench for seq_run_ctrl (TICK_DIV=4, CYCLE_LEN=8, RUN_CYCLES=2) with a strobe-event scoreboard.
module tb_seq_run_ctrl;
  import seq_run_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       CR_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0, mode_req = 1'b0;
  logic       step_en, seq_clr, mode_out, mode_pend, done;
  logic [3:0] step_idx;
  logic [1:0] state_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [2:0] bits;   // {done, seq_clr, step_en}
    logic [3:0] idx;
  } ev_t;
  ev_t exp_q[$];

  seq_run_ctrl #(.TICK_DIV(4), .CNT_W(2), .CYCLE_LEN(8), .RUN_CYCLES(2)) dut (
    .clk       (clk),
    .CR_n      (CR_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .step      (step),
    .mode_req  (mode_req),
    .step_en   (step_en),
    .seq_clr   (seq_clr),
    .mode_out  (mode_out),
    .mode_pend (mode_pend),
    .step_idx  (step_idx),
    .state_o   (state_o),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobes registered on posedge N are seen here with cyc == N.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $error("FAIL missed_event cyc=%0d expected bits=%b idx=%0d", exp_q[0].cyc, exp_q[0].bits, exp_q[0].idx);
      void'(exp_q.pop_front());
    end
    if (step_en || seq_clr || done) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_event cyc=%0d bits=%b idx=%0d", cyc, {done, seq_clr, step_en}, step_idx);
      end
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        assert (e.cyc == cyc && e.bits === {done, seq_clr, step_en} && e.idx === step_idx) else begin
          miscompares++;
          $error("FAIL event observed cyc=%0d bits=%b idx=%0d expected cyc=%0d bits=%b idx=%0d",
                 cyc, {done, seq_clr, step_en}, step_idx, e.cyc, e.bits, e.idx);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [2:0] bits, input logic [3:0] idx);
    ev_t e;
    e.cyc = c; e.bits = bits; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; pulses inputs for exactly one posedge, returns at the following negedge.
  task automatic cmd(input logic s, input logic t, input logic p, input logic st, output int e);
    start = s; stop = t; pause = p; step = st;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; pause = 1'b0; step = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e0, r, e;

    // Reset state
    #1 CR_n = 1'b0;
    #1;
    chk("rst_state", 8'(state_o), 8'(S_IDLE));
    chk("rst_idx", 8'(step_idx), 8'd0);
    chk("rst_strobes", 8'({done, seq_clr, step_en}), 8'd0);
    wait_cyc(2);
    CR_n = 1'b1;
    wait_cyc(2);

    // Stop in IDLE: seq_clr only
    cmd(0, 1, 0, 0, e);
    push(e, 3'b010, 4'd0);
    chk("idle_stop_state", 8'(state_o), 8'(S_IDLE));

    // Start: seq_clr then step_en every 4 clocks
    wait_cyc(2);
    cmd(1, 0, 0, 0, e0);
    push(e0, 3'b010, 4'd0);
    for (int k = 1; k <= 3; k++) push(e0 + 4 * k, 3'b001, 4'(k));
    chk("run_state", 8'(state_o), 8'(S_RUN));
    wait_cyc(12);
    chk("run_idx3", 8'(step_idx), 8'd3);

    // Pause after 2 timer counts, single step, resume
    wait_cyc(2);
    cmd(0, 0, 1, 0, e);
    chk("pause_state", 8'(state_o), 8'(S_PAUSE));
    wait_cyc(20);
    chk("pause_hold_idx", 8'(step_idx), 8'd3);
    cmd(0, 0, 0, 1, e);
    push(e, 3'b001, 4'd4);
    chk("pause_step_idx", 8'(step_idx), 8'd4);
    cmd(0, 0, 1, 0, r);
    push(r + 2, 3'b001, 4'd5);
    chk("resume_state", 8'(state_o), 8'(S_RUN));
    wait_cyc(2);

    // Mode change waits for the cycle wrap
    mode_req = 1'b1;
    wait_cyc(1);
    chk("mode_pend_set", 8'({mode_out, mode_pend}), 8'b01);
    push(r + 6, 3'b001, 4'd6);
    push(r + 10, 3'b001, 4'd7);
    push(r + 14, 3'b001, 4'd0);
    wait_cyc(10);
    chk("mode_before_wrap", 8'({mode_out, mode_pend}), 8'b01);
    wait_cyc(1);
    chk("mode_after_wrap", 8'({mode_out, mode_pend}), 8'b10);

    // stop+start together in RUN: stop wins
    cmd(1, 1, 0, 0, e);
    push(e, 3'b010, 4'd0);
    chk("stopstart_state", 8'(state_o), 8'(S_IDLE));
    wait_cyc(10);
    chk("stopstart_idle", 8'(state_o), 8'(S_IDLE));

    // start+pause together in IDLE: RUN only
    cmd(1, 0, 1, 0, e);
    push(e, 3'b010, 4'd0);
    push(e + 4, 3'b001, 4'd1);
    chk("startpause_state", 8'(state_o), 8'(S_RUN));
    wait_cyc(6);

    // Asynchronous reset mid-RUN
    #2 CR_n = 1'b0;
    mode_req = 1'b0;
    #1;
    chk("arst_state", 8'(state_o), 8'(S_IDLE));
    chk("arst_outs", 8'({step_en, seq_clr, mode_out}), 8'd0);
    chk("arst_idx", 8'(step_idx), 8'd0);
    wait_cyc(3);
    CR_n = 1'b1;
    wait_cyc(6);
    chk("post_rst_state", 8'(state_o), 8'(S_IDLE));
    chk("post_rst_mode_idx", 8'({mode_out, step_idx}), 8'd0);
    mode_req = 1'b1;
    wait_cyc(1);
    chk("idle_mode_follow", 8'({mode_out, mode_pend}), 8'b10);
    mode_req = 1'b0;
    wait_cyc(1);

    // Long run: auto-stop after 2 cycles when the limit is built in
    cmd(1, 0, 0, 0, e);
    push(e, 3'b010, 4'd0);
`ifdef SEQ_RUN_LIMIT_EN
    for (int k = 1; k <= 16; k++) push(e + 4 * k, (k == 16) ? 3'b101 : 3'b001, 4'(k % 8));
    wait_cyc(64);
    chk("limit_state", 8'(state_o), 8'(S_IDLE));
    wait_cyc(8);
    chk("limit_hold", 8'(state_o), 8'(S_IDLE));
`else
    for (int k = 1; k <= 16; k++) push(e + 4 * k, 3'b001, 4'(k % 8));
    wait_cyc(64);
    chk("nolimit_state", 8'(state_o), 8'(S_RUN));
    cmd(0, 1, 0, 0, r);
    push(r, 3'b010, 4'd0);
    wait_cyc(8);
    chk("nolimit_stop", 8'(state_o), 8'(S_IDLE));
`endif

    wait_cyc(2);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
